uart_tx_fifo: RTL

Byte FIFO that sits directly upstream of the `uart` transmitter. It accepts bytes from a host-side write port at up to one per clock. It drains them one at a time into the UART through the UART's `tx_byte` / `tx_req` / `tx_busy` handshake, never issuing a request while a byte is still being serialised. This lets firmware or logic burst short messages without polling `tx_busy` per byte.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into a UART transmitter via tx_req/tx_busy
//
// Ports:
//   i_clk            system clock, shared with the UART
//   i_reset          asynchronous active-high reset
//   i_wr_data[7:0]   byte to enqueue
//   i_wr_en          enqueue i_wr_data this cycle
//   i_flush          synchronous discard of all queued (not in-flight) bytes
//   o_full           no free entry
//   o_empty          no queued entry
//   o_level          number of queued entries, 0..2^DEPTH_LOG2
//   o_overflow       sticky: a write was dropped while full
//   o_drained        empty, drain FSM idle and UART not busy
//   o_uart_tx_byte   byte presented to the UART
//   o_uart_tx_req    one-cycle transmit request to the UART
//   i_uart_tx_busy   UART is serialising a frame

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_en,
    input  logic                  i_flush,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_drained,
    output logic [7:0]            o_uart_tx_byte,
    output logic                  o_uart_tx_req,
    input  logic                  i_uart_tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [7:0]            r_tx_byte;
    logic                  r_tx_req;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // Fullness is judged on the registered count, so a write into a full
    // FIFO is dropped even when a pop frees an entry on the same edge.
    assign w_push = i_wr_en && !w_full && !i_flush;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !i_uart_tx_busy && !i_flush) begin
                    w_pop        = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_uart_tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_uart_tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage carries no reset; entries are only observed once written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_byte  <= 8'h00;
            r_tx_req   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Request is high only during the REQ state that follows a pop.
            r_tx_req <= w_pop;

            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr];
            end

            // A flushed write is discarded silently, never counted as overflow.
            if (i_wr_en && w_full && !i_flush) begin
                r_overflow <= 1'b1;
            end

            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_level        = r_count;
    assign o_overflow     = r_overflow;
    assign o_drained      = w_empty && (r_state == S_IDLE) && !i_uart_tx_busy;
    assign o_uart_tx_byte = r_tx_byte;
    assign o_uart_tx_req  = r_tx_req;

endmodule
